// File: rtl/share_serializer.sv
// Serializes a parallel word into (d+1)*PAR-bit share chunks, LSB- or MSB-chunk first,
// with a per-word chunk count, ready/valid backpressure, abort and a completion pulse.
module share_serializer #(
    parameter int WIDTH        = 64,
    parameter int PAR          = 1,
    parameter int d            = 2,
    parameter int SHIFT_WIDTH  = (d + 1) * PAR,
    parameter int NCHUNK       = (WIDTH + SHIFT_WIDTH - 1) / SHIFT_WIDTH,
    parameter int PADDED_WIDTH = NCHUNK * SHIFT_WIDTH,
    parameter int CW           = $clog2(NCHUNK + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [CW-1:0]          len,
    input  logic                   msb_first,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SHIFT_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic                   done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [PADDED_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [CW-1:0]           leff_q, leff_d;
    logic                    msb_q, msb_d;
    logic                    done_q, done_d;

    logic [CW-1:0]           last_idx;
    logic [CW-1:0]           chunk_idx;
    logic [PADDED_WIDTH-1:0] shifted;
    logic                    is_last;

    // cnt_q counts chunks already transferred; the presented chunk index
    // is derived from it so the register never has to move.
    always_comb begin
        last_idx  = leff_q - CW'(1);
        chunk_idx = msb_q ? (last_idx - cnt_q) : cnt_q;
        shifted   = data_q >> (chunk_idx * SHIFT_WIDTH);
        is_last   = (cnt_q == last_idx);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        leff_d  = leff_q;
        msb_d   = msb_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = PADDED_WIDTH'(data_in);
                    leff_d  = (len == '0 || len > CW'(NCHUNK)) ? CW'(NCHUNK) : len;
                    msb_d   = msb_first;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            leff_q  <= '0;
            msb_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            leff_q  <= leff_d;
            msb_q   <= msb_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == SHIFT);
    assign out_last  = (state_q == SHIFT) && is_last;
    assign out_data  = (state_q == SHIFT) ? shifted[SHIFT_WIDTH-1:0] : '0;
    assign done      = done_q;

endmodule

// File: tb/tb_share_serializer.sv
// Directed bench for share_serializer at WIDTH=64, d=2, PAR=1 (3-bit chunks, 22 chunks/word).
module tb_share_serializer;

    localparam int WIDTH = 64;
    localparam int SW    = 3;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             reset, in_valid, in_ready, msb_first, abort;
    logic             out_valid, out_ready, out_last, done;
    logic [WIDTH-1:0] data_in;
    logic [CW-1:0]    len;
    logic [SW-1:0]    out_data;

    int errors = 0;
    int checks = 0;

    share_serializer #(.WIDTH(64), .PAR(1), .d(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .len(len), .msb_first(msb_first), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] dat, input logic [CW-1:0] l, input logic msb);
        in_valid = 1'b1; data_in = dat; len = l; msb_first = msb;
        step();
        in_valid = 1'b0; data_in = '0; len = '0; msb_first = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; data_in = '0; len = '0; msb_first = 1'b0;
        abort = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (out_data !== 3'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    endtask

    // Three-chunk word 0xFA: chunks are 2, 7, 3 from the LSB end.
    task automatic test_three(input string name, input logic msb);
        logic [SW-1:0] exp [3];
        if (msb) begin exp[0] = 3'd3; exp[1] = 3'd7; exp[2] = 3'd2; end
        else     begin exp[0] = 3'd2; exp[1] = 3'd7; exp[2] = 3'd3; end
        out_ready = 1'b1;
        load(64'hFA, 5'd3, msb);
        for (int k = 0; k < 3; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 2) || done !== 1'b0) begin
                errors++; $display("FAIL %s_chunk%0d got v=%b d=%0d l=%b dn=%b exp v=1 d=%0d l=%b dn=0",
                                   name, k, out_valid, out_data, out_last, done, exp[k], k == 2);
            end
            step();
        end
        checks++; if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 3'd0) begin
            errors++; $display("FAIL %s_done got dn=%b rdy=%b v=%b d=%0d exp dn=1 rdy=1 v=0 d=0",
                               name, done, in_ready, out_valid, out_data);
        end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        out_ready = 1'b0;
        load(64'hFA, 5'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 3'd2 || out_last !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got v=%b d=%0d l=%b exp v=1 d=2 l=0", i, out_valid, out_data, out_last);
            end
            if (i == 4) out_ready = 1'b1;
            if (out_valid && out_ready) xfers++;
            step();
        end
        checks++; if (out_data !== 3'd7 || out_last !== 1'b0) begin
            errors++; $display("FAIL stall_chunk1 got d=%0d l=%b exp d=7 l=0", out_data, out_last);
        end
        if (out_valid && out_ready) xfers++;
        step();
        checks++; if (out_data !== 3'd3 || out_last !== 1'b1) begin
            errors++; $display("FAIL stall_chunk2 got d=%0d l=%b exp d=3 l=1", out_data, out_last);
        end
        if (out_valid && out_ready) xfers++;
        step();
        if (out_valid && out_ready) xfers++;
        checks++; if (xfers != 3 || done !== 1'b1) begin
            errors++; $display("FAIL stall_xfers got n=%0d dn=%b exp n=3 dn=1", xfers, done);
        end
        step();
    endtask

    task automatic test_full_length();
        int xfers = 0;
        int lasts = 0;
        out_ready = 1'b1;
        load(64'h8000_0000_0000_0001, 5'd0, 1'b0);
        for (int k = 0; k < 22; k++) begin
            logic [SW-1:0] e;
            e = (k == 0 || k == 21) ? 3'd1 : 3'd0;
            checks++; if (out_valid !== 1'b1 || out_data !== e || out_last !== (k == 21)) begin
                errors++; $display("FAIL full_chunk%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                                   k, out_valid, out_data, out_last, e, k == 21);
            end
            if (out_valid) xfers++;
            if (out_last) lasts++;
            step();
        end
        checks++; if (xfers != 22 || lasts != 1 || done !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL full_end got n=%0d lasts=%0d dn=%b v=%b exp n=22 lasts=1 dn=1 v=0",
                               xfers, lasts, done, out_valid);
        end
        step();
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        load(64'hFA, 5'd3, 1'b0);
        step(); step();
        checks++; if (out_data !== 3'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL abort_pre got v=%b d=%0d exp v=1 d=3", out_valid, out_data);
        end
        abort = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== 3'd0) begin
            errors++; $display("FAIL abort_idle got rdy=%b v=%b dn=%b d=%0d exp rdy=1 v=0 dn=0 d=0",
                               in_ready, out_valid, done, out_data);
        end
        // abort stays high in IDLE alongside a new load; the load must win.
        load(64'h5, 5'd1, 1'b0);
        abort = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 3'd5 || out_last !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL abort_reload got v=%b d=%0d l=%b dn=%b exp v=1 d=5 l=1 dn=0",
                               out_valid, out_data, out_last, done);
        end
        step();
        checks++; if (done !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL abort_reload_done got dn=%b rdy=%b v=%b exp dn=1 rdy=1 v=0", done, in_ready, out_valid);
        end
        step();
    endtask

    task automatic test_reset_midword();
        out_ready = 1'b1;
        load(64'hFA, 5'd3, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || out_data !== 3'd0) begin
            errors++; $display("FAIL midreset got rdy=%b v=%b l=%b dn=%b d=%0d exp rdy=1 v=0 l=0 dn=0 d=0",
                               in_ready, out_valid, out_last, done, out_data);
        end
        step();
        checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_after got dn=%b v=%b exp dn=0 v=0", done, out_valid);
        end
        test_three("post_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_three("lsb", 1'b0);
        test_three("msb", 1'b1);
        test_backpressure();
        test_full_length();
        test_abort();
        test_reset_midword();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/share_serializer.md
SHARE_SERIALIZER -- requirements
Module: share_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 64: bit width of the parallel word loaded.
REQ-002 SHALL have parameter PAR, default 1: bits per share emitted per chunk.
REQ-003 SHALL have parameter d, default 2: masking order; share count is d+1.
REQ-004 SHALL have parameter SHIFT_WIDTH, default (d+1)*PAR: chunk width.
REQ-005 SHALL have parameter NCHUNK, default ceil(WIDTH/SHIFT_WIDTH): chunks per full word.
REQ-006 SHALL have parameter PADDED_WIDTH, default NCHUNK*SHIFT_WIDTH: internal register width.
REQ-007 SHALL have parameter CW, default $clog2(NCHUNK+1): width of the length field.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port in_valid, input, 1 bit: load request.
REQ-011 SHALL have port in_ready, output, 1 bit: block can accept a load.
REQ-012 SHALL have port data_in, input, WIDTH bits: parallel word.
REQ-013 SHALL have port len, input, CW bits: chunk count for this word.
REQ-014 SHALL have port msb_first, input, 1 bit: emission order for this word.
REQ-015 SHALL have port abort, input, 1 bit: cancel the word in flight.
REQ-016 SHALL have port out_valid, output, 1 bit: chunk valid.
REQ-017 SHALL have port out_ready, input, 1 bit: consumer accepts the chunk.
REQ-018 SHALL have port out_data, output, SHIFT_WIDTH bits: current chunk.
REQ-019 SHALL have port out_last, output, 1 bit: current chunk is the final one.
REQ-020 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-021 SHALL implement FSM states IDLE and SHIFT; in_ready=1 only in IDLE; out_valid=1 only in SHIFT.
REQ-022 IDLE, in_valid=1: SHALL capture data_in zero-extended on the left to PADDED_WIDTH, capture len and msb_first, clear counter, enter SHIFT next cycle.
REQ-023 len=0 or len>NCHUNK SHALL be treated as NCHUNK; effective length Leff lies in 1..NCHUNK.
REQ-024 Chunk k = padded bits [k*SHIFT_WIDTH +: SHIFT_WIDTH].
REQ-025 LSB-first SHALL emit chunks 0..Leff-1; MSB-first SHALL emit chunks Leff-1 down to 0.
REQ-026 Transfer occurs on out_valid & out_ready; out_data SHALL advance to the next chunk the following cycle.
REQ-027 With out_ready=0, out_data, out_valid and out_last SHALL hold stable.
REQ-028 out_last SHALL be 1 exactly while the Leff-th chunk is presented.
REQ-029 Transfer of the last chunk SHALL return the FSM to IDLE; done=1 for exactly the next cycle (IDLE, in_ready=1).
REQ-030 Minimum cycle from load accept to first out_valid SHALL be 1; back-to-back transfers SHALL sustain one chunk per cycle.
REQ-031 abort=1 in SHIFT SHALL return to IDLE next cycle with no done and no further chunks; abort overrides a same-cycle transfer; abort in IDLE SHALL be ignored and SHALL not block a same-cycle load.
REQ-032 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-033 reset=1 at a rising edge SHALL force IDLE, clear register, counter and captured fields; next cycle in_ready=1, out_valid=0, out_last=0, done=0, out_data=0.
REQ-034 reset SHALL take priority over load, transfer and abort, including mid-word; no done SHALL follow a reset.

Verification (WIDTH=64, d=2, PAR=1: SHIFT_WIDTH=3, NCHUNK=22)
REQ-035 data_in=0xFA, len=3, msb_first=0, out_ready=1 -> out_data 3'd2, 3'd7, 3'd3 on consecutive cycles, out_last on 3rd, done the cycle after.
REQ-036 Same with msb_first=1 -> 3'd3, 3'd7, 3'd2; out_last on 3rd.
REQ-037 data_in=0xFA, len=3, out_ready low 4 cycles after first chunk -> out_data held at 3'd2 for 5 cycles, then 3'd7, 3'd3; exactly 3 transfers.
REQ-038 data_in=0x8000_0000_0000_0001, len=0 -> 22 transfers, first 3'd1, last 3'd1 ({2'b00, bit63}), out_last only on 22nd.
REQ-039 abort after 2nd transfer -> IDLE next cycle, no done, in_ready=1; new load of 0x5, len=1 -> single chunk 3'd5 with out_last and done.
REQ-040 reset asserted mid-word -> all outputs at reset values next cycle; subsequent load behaves as REQ-035.
